// File: rtl/avl_arbiter_pkg.sv
// Shared types for the instruction/data arbiter in front of the single-port Avalon bridge.
package avl_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_INSTR = 1'b0,
      GNT_DATA  = 1'b1
   } grant_t;

   localparam int unsigned AVL_ADDR_W = 32;
   localparam int unsigned AVL_DATA_W = 32;
   localparam int unsigned AVL_STRB_W = AVL_DATA_W / 8;

   // Buffered data-port request at the default bus widths.
   typedef struct packed {
      logic [AVL_ADDR_W-1:0] addr;
      logic [AVL_DATA_W-1:0] wdata;
      logic [AVL_STRB_W-1:0] wstrb;
   } avl_req_t;

   // On contention the requester that was not served last wins.
   function automatic grant_t pick_grant(input logic pend_i, input logic pend_d,
                                         input grant_t last);
      if (pend_i && pend_d) return (last == GNT_DATA) ? GNT_INSTR : GNT_DATA;
      return pend_d ? GNT_DATA : GNT_INSTR;
   endfunction

endpackage

// File: rtl/avl_arbiter_req_buffer.sv
// One-entry pending request register; a set on the same edge as a clear wins.
module avl_req_buffer #(
   parameter int unsigned W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_set,
   input  logic         i_clr,
   input  logic [W-1:0] i_data,
   output logic         o_pending,
   output logic [W-1:0] o_data
);

   logic         r_pending;
   logic [W-1:0] r_data;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pending <= 1'b0;
         r_data    <= '0;
      end else if (i_set) begin
         r_pending <= 1'b1;
         r_data    <= i_data;
      end else if (i_clr) begin
         r_pending <= 1'b0;
      end
   end

   assign o_pending = r_pending;
   assign o_data    = r_data;

endmodule

// File: rtl/avl_arbiter.sv
// Round-robin arbiter sharing one Avalon bridge between instruction fetch and data memory;
// one transaction in flight, response routed to the granted requester only.
module avl_arbiter
   import avl_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = AVL_ADDR_W,
   parameter int unsigned DATA_W = AVL_DATA_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ready,
   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ready,
   output logic                avl_valid,
   output logic                avl_instr,
   output logic [ADDR_W-1:0]   avl_addr,
   output logic [DATA_W-1:0]   avl_wdata,
   output logic [DATA_W/8-1:0] avl_wstrb,
   input  logic [DATA_W-1:0]   avl_rdata,
   input  logic                avl_ready
);

   localparam int unsigned STRB_W = DATA_W / 8;

   // Width-parametric counterpart of avl_req_t.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } dreq_t;

   arb_state_t        r_state, w_state_nxt;
   grant_t            r_last_grant, w_last_grant_nxt;
   logic              w_pend_i, w_pend_d;
   logic              w_gnt_i, w_gnt_d;
   logic [ADDR_W-1:0] w_buf_iaddr;
   dreq_t             w_dreq_in, w_buf_dreq;

   logic              r_avl_valid;
   logic              r_avl_instr;
   logic [ADDR_W-1:0] r_avl_addr;
   logic [DATA_W-1:0] r_avl_wdata;
   logic [STRB_W-1:0] r_avl_wstrb;

   assign w_dreq_in = '{addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};

   avl_req_buffer #(.W(ADDR_W)) u_ibuf (
      .clock     (clock),
      .reset     (reset),
      .i_set     (i_valid),
      .i_clr     (w_gnt_i),
      .i_data    (i_addr),
      .o_pending (w_pend_i),
      .o_data    (w_buf_iaddr)
   );

   avl_req_buffer #(.W($bits(dreq_t))) u_dbuf (
      .clock     (clock),
      .reset     (reset),
      .i_set     (d_valid),
      .i_clr     (w_gnt_d),
      .i_data    (w_dreq_in),
      .o_pending (w_pend_d),
      .o_data    (w_buf_dreq)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GNT_DATA;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   // Arbitration looks only at the pending registers, never at same-cycle valids.
   always_comb begin
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;
      w_gnt_i          = 1'b0;
      w_gnt_d          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pend_i || w_pend_d) begin
               if (pick_grant(w_pend_i, w_pend_d, r_last_grant) == GNT_INSTR) begin
                  w_gnt_i          = 1'b1;
                  w_state_nxt      = ST_BUSY_I;
                  w_last_grant_nxt = GNT_INSTR;
               end else begin
                  w_gnt_d          = 1'b1;
                  w_state_nxt      = ST_BUSY_D;
                  w_last_grant_nxt = GNT_DATA;
               end
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (avl_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_avl_valid <= 1'b0;
         r_avl_instr <= 1'b0;
         r_avl_addr  <= '0;
         r_avl_wdata <= '0;
         r_avl_wstrb <= '0;
      end else begin
         r_avl_valid <= w_gnt_i | w_gnt_d;
         if (w_gnt_i) begin
            r_avl_instr <= 1'b1;
            r_avl_addr  <= w_buf_iaddr;
            r_avl_wdata <= '0;
            r_avl_wstrb <= '0;
         end else if (w_gnt_d) begin
            r_avl_instr <= 1'b0;
            r_avl_addr  <= w_buf_dreq.addr;
            r_avl_wdata <= w_buf_dreq.wdata;
            r_avl_wstrb <= w_buf_dreq.wstrb;
         end
      end
   end

   assign avl_valid = r_avl_valid;
   assign avl_instr = r_avl_instr;
   assign avl_addr  = r_avl_addr;
   assign avl_wdata = r_avl_wdata;
   assign avl_wstrb = r_avl_wstrb;

   // A bridge ready seen while IDLE matches no grant and is dropped here.
   assign i_ready = avl_ready && (r_state == ST_BUSY_I);
   assign d_ready = avl_ready && (r_state == ST_BUSY_D);
   assign i_rdata = (r_state == ST_BUSY_I) ? avl_rdata : '0;
   assign d_rdata = (r_state == ST_BUSY_D) ? avl_rdata : '0;

endmodule

// File: tb/tb_avl_arbiter.sv
// Scoreboard bench for avl_arbiter: directed requests, a behavioural bridge, and a negedge monitor.
module tb_avl_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          i_valid = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_rdata;
   logic          i_ready;
   logic          d_valid = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [SW-1:0] d_wstrb = '0;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          avl_valid;
   logic          avl_instr;
   logic [AW-1:0] avl_addr;
   logic [DW-1:0] avl_wdata;
   logic [SW-1:0] avl_wstrb;
   logic [DW-1:0] avl_rdata = '0;
   logic          avl_ready = 1'b0;

   avl_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock     (clock),
      .reset     (reset),
      .i_valid   (i_valid),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_ready   (i_ready),
      .d_valid   (d_valid),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wstrb   (d_wstrb),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .avl_valid (avl_valid),
      .avl_instr (avl_instr),
      .avl_addr  (avl_addr),
      .avl_wdata (avl_wdata),
      .avl_wstrb (avl_wstrb),
      .avl_rdata (avl_rdata),
      .avl_ready (avl_ready)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic          instr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      int            exp_cyc;
      int            exp_gap;
   } avl_exp_t;

   typedef struct {
      logic          is_d;
      logic          chk_data;
      logic [DW-1:0] rdata;
   } rsp_exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
   } req_t;

   avl_exp_t      exp_avl[$];
   rsp_exp_t      exp_rsp[$];
   logic [DW-1:0] br_q[$];
   req_t          iq[$];
   req_t          dq[$];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic req_t mk_req(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                   input logic [SW-1:0] ws);
      req_t r;
      r.addr  = a;
      r.wdata = wd;
      r.wstrb = ws;
      return r;
   endfunction

   function automatic void exp_issue(input logic instr, input logic [AW-1:0] a,
                                     input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                                     input int ec, input int eg);
      avl_exp_t e;
      e.instr   = instr;
      e.addr    = a;
      e.wdata   = wd;
      e.wstrb   = ws;
      e.exp_cyc = ec;
      e.exp_gap = eg;
      exp_avl.push_back(e);
   endfunction

   // Bridge returns responses in issue order, so the rdata queue follows the response queue.
   function automatic void exp_ready(input logic is_d, input logic chk_data, input logic [DW-1:0] rd);
      rsp_exp_t e;
      e.is_d     = is_d;
      e.chk_data = chk_data;
      e.rdata    = rd;
      exp_rsp.push_back(e);
      br_q.push_back(rd);
   endfunction

   // Behavioural bridge: answers br_lat cycles after avl_valid unless held.
   int   br_lat   = 2;
   int   br_cnt   = 0;
   logic br_busy  = 1'b0;
   logic br_hold  = 1'b0;
   logic br_stray = 1'b0;

   initial begin
      forever begin
         @(posedge clock);
         #1;
         avl_ready = 1'b0;
         avl_rdata = '0;
         if (br_stray) begin
            avl_ready = 1'b1;
            avl_rdata = 32'hBAD0_BAD0;
            br_stray  = 1'b0;
         end else if (br_busy && !br_hold) begin
            if (br_cnt <= 0) begin
               avl_ready = 1'b1;
               avl_rdata = (br_q.size() != 0) ? br_q.pop_front() : '0;
               br_busy   = 1'b0;
            end else begin
               br_cnt--;
            end
         end
         if (avl_valid && reset) begin
            br_busy = 1'b1;
            br_cnt  = br_lat - 1;
         end
      end
   end

   // Monitor
   logic     mon_busy = 1'b0;
   int       last_rdy = -100;
   avl_exp_t ea;
   rsp_exp_t er;

   always @(negedge clock) begin
      if (!reset) begin
         mon_busy = 1'b0;
      end else begin
         if (avl_valid) begin
            chk("avl_valid while busy", {63'd0, mon_busy}, 64'd0);
            if (exp_avl.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected avl_valid: addr 0x%0h issued, no issue required", avl_addr);
            end else begin
               ea = exp_avl.pop_front();
               chk("avl_instr", {63'd0, avl_instr}, {63'd0, ea.instr});
               chk("avl_addr", {32'd0, avl_addr}, {32'd0, ea.addr});
               chk("avl_wdata", {32'd0, avl_wdata}, {32'd0, ea.wdata});
               chk("avl_wstrb", {60'd0, avl_wstrb}, {60'd0, ea.wstrb});
               if (ea.exp_cyc >= 0) chk("issue cycle", 64'(cyc), 64'(ea.exp_cyc));
               if (ea.exp_gap >= 0) chk("ready-to-issue gap", 64'(cyc - last_rdy), 64'(ea.exp_gap));
            end
            mon_busy = 1'b1;
         end
         if (i_ready || d_ready) begin
            if (exp_rsp.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected ready: i_ready=%0b d_ready=%0b, none required", i_ready, d_ready);
            end else begin
               er = exp_rsp.pop_front();
               chk("ready routing", {62'd0, i_ready, d_ready}, er.is_d ? 64'd1 : 64'd2);
               if (er.is_d) begin
                  chk("i_rdata on d grant", {32'd0, i_rdata}, 64'd0);
                  if (er.chk_data) chk("d_rdata", {32'd0, d_rdata}, {32'd0, er.rdata});
               end else begin
                  chk("i_rdata", {32'd0, i_rdata}, {32'd0, er.rdata});
                  chk("d_rdata on i grant", {32'd0, d_rdata}, 64'd0);
               end
            end
         end
         if (avl_ready) begin
            mon_busy = 1'b0;
            last_rdy = cyc;
         end
      end
   end

   task automatic issue(input logic do_i, input logic [AW-1:0] ia, input logic do_d,
                        input req_t dr, output int k);
      @(posedge clock);
      #1;
      k       = cyc;
      i_valid = do_i;
      i_addr  = ia;
      d_valid = do_d;
      d_addr  = dr.addr;
      d_wdata = dr.wdata;
      d_wstrb = dr.wstrb;
      @(posedge clock);
      #1;
      i_valid = 1'b0;
      d_valid = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int c = 0;
      while ((exp_avl.size() != 0 || exp_rsp.size() != 0) && c < max_cyc) begin
         @(negedge clock);
         c++;
      end
      if (c >= max_cyc) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain timeout: %0d issues, %0d responses outstanding, required 0",
                  exp_avl.size(), exp_rsp.size());
      end
      repeat (2) @(posedge clock);
   endtask

   // Re-requests in the same cycle as the requester's own ready, from iq/dq.
   task automatic react(input int max_cyc);
      int   c = 0;
      req_t r;
      while ((exp_avl.size() != 0 || exp_rsp.size() != 0) && c < max_cyc) begin
         @(negedge clock);
         c++;
         i_valid = 1'b0;
         d_valid = 1'b0;
         if (i_ready && iq.size() != 0) begin
            r       = iq.pop_front();
            i_valid = 1'b1;
            i_addr  = r.addr;
         end
         if (d_ready && dq.size() != 0) begin
            r       = dq.pop_front();
            d_valid = 1'b1;
            d_addr  = r.addr;
            d_wdata = r.wdata;
            d_wstrb = r.wstrb;
         end
      end
      i_valid = 1'b0;
      d_valid = 1'b0;
      if (c >= max_cyc) begin
         n_tests++;
         n_fail++;
         $display("FAIL react timeout: %0d issues, %0d responses outstanding, required 0",
                  exp_avl.size(), exp_rsp.size());
      end
      repeat (2) @(posedge clock);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int k2;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("reset avl_valid", {63'd0, avl_valid}, 64'd0);
      chk("reset avl_instr", {63'd0, avl_instr}, 64'd0);
      chk("reset avl_addr", {32'd0, avl_addr}, 64'd0);
      chk("reset avl_wdata", {32'd0, avl_wdata}, 64'd0);
      chk("reset avl_wstrb", {60'd0, avl_wstrb}, 64'd0);
      chk("reset i_ready", {63'd0, i_ready}, 64'd0);
      chk("reset d_ready", {63'd0, d_ready}, 64'd0);
      @(negedge clock);
      reset = 1'b1;

      // Single load
      exp_ready(1'b1, 1'b1, 32'hDEAD_BEEF);
      issue(1'b0, '0, 1'b1, mk_req(32'h0000_1000, '0, '0), k);
      exp_issue(1'b0, 32'h0000_1000, '0, '0, k + 2, -1);
      drain(100);

      // Store
      exp_ready(1'b1, 1'b0, '0);
      issue(1'b0, '0, 1'b1, mk_req(32'h0000_2000, 32'h1234_5678, 4'h3), k);
      exp_issue(1'b0, 32'h0000_2000, 32'h1234_5678, 4'h3, k + 2, -1);
      drain(100);

      // Simultaneous requests straight after reset: INSTR first, DATA at M+2
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset  = 1'b1;
      br_lat = 3;
      exp_ready(1'b0, 1'b1, 32'h1111_1111);
      exp_ready(1'b1, 1'b1, 32'h2222_2222);
      issue(1'b1, 32'h0000_0100, 1'b1, mk_req(32'h0000_0200, '0, '0), k);
      exp_issue(1'b1, 32'h0000_0100, '0, '0, k + 2, -1);
      exp_issue(1'b0, 32'h0000_0200, '0, '0, -1, 2);
      drain(100);

      // Fairness: 20 transactions, strict I/D alternation, each issue two cycles after ready
      br_lat = 2;
      for (int j = 0; j < 10; j++) begin
         exp_ready(1'b0, 1'b1, 32'hA000_0000 + j);
         exp_ready(1'b1, 1'b1, 32'hB000_0000 + j);
         exp_issue(1'b1, 32'h0001_0000 + 16 * j, '0, '0, -1, (j == 0) ? -1 : 2);
         exp_issue(1'b0, 32'h0002_0000 + 16 * j, '0, '0, -1, 2);
         if (j > 0) begin
            iq.push_back(mk_req(32'h0001_0000 + 16 * j, '0, '0));
            dq.push_back(mk_req(32'h0002_0000 + 16 * j, '0, '0));
         end
      end
      issue(1'b1, 32'h0001_0000, 1'b1, mk_req(32'h0002_0000, '0, '0), k);
      react(600);

      // Same-cycle reissue on the data port
      exp_ready(1'b1, 1'b1, 32'h3333_3333);
      exp_ready(1'b1, 1'b0, '0);
      dq.push_back(mk_req(32'h0000_3004, 32'h55AA_55AA, 4'hF));
      issue(1'b0, '0, 1'b1, mk_req(32'h0000_3000, '0, '0), k);
      exp_issue(1'b0, 32'h0000_3000, '0, '0, k + 2, -1);
      exp_issue(1'b0, 32'h0000_3004, 32'h55AA_55AA, 4'hF, -1, 2);
      react(200);

      // Reset during BUSY_D with an instruction request pending
      br_hold = 1'b1;
      issue(1'b0, '0, 1'b1, mk_req(32'h0000_4000, 32'hCAFE_0000, 4'hC), k);
      exp_issue(1'b0, 32'h0000_4000, 32'hCAFE_0000, 4'hC, k + 2, -1);
      repeat (3) @(posedge clock);
      issue(1'b1, 32'h0000_5000, 1'b0, mk_req('0, '0, '0), k2);
      @(negedge clock);
      chk("avl_addr held in BUSY_D", {32'd0, avl_addr}, 64'h4000);
      #2;
      reset = 1'b0;
      #1;
      chk("mid-reset avl_valid", {63'd0, avl_valid}, 64'd0);
      chk("mid-reset avl_instr", {63'd0, avl_instr}, 64'd0);
      chk("mid-reset avl_addr", {32'd0, avl_addr}, 64'd0);
      chk("mid-reset avl_wdata", {32'd0, avl_wdata}, 64'd0);
      chk("mid-reset avl_wstrb", {60'd0, avl_wstrb}, 64'd0);
      chk("mid-reset d_ready", {63'd0, d_ready}, 64'd0);
      br_busy = 1'b0;
      br_hold = 1'b0;
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      br_stray = 1'b1;
      @(negedge clock);
      chk("stray avl_ready present", {63'd0, avl_ready}, 64'd1);
      chk("stray i_ready", {63'd0, i_ready}, 64'd0);
      chk("stray d_ready", {63'd0, d_ready}, 64'd0);
      chk("stray i_rdata", {32'd0, i_rdata}, 64'd0);
      chk("stray d_rdata", {32'd0, d_rdata}, 64'd0);
      repeat (12) @(posedge clock);
      @(negedge clock);
      chk("issues outstanding at end", 64'(exp_avl.size()), 64'd0);
      chk("responses outstanding at end", 64'(exp_rsp.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
